// File: rtl/stp_pkg.sv
// Shared types and helpers for the serial-to-parallel word collector.
package stp_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } stp_state_t;

  // Width needed to hold a word count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stp_word_shift.sv
// Block shift register: one word enters per shift strobe, zero strobe wipes the block.
// Latency 1 cycle from strobe to o_data; no backpressure of its own.
module stp_word_shift #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_zero,
  input  logic                        i_shift,
  input  logic [WORD_W-1:0]           i_word,
  output logic [WORD_W*NUM_WORDS-1:0] o_data
);

  localparam int DW = WORD_W * NUM_WORDS;

  logic [DW-1:0] r_data;
  logic [DW-1:0] w_next;

  // Words enter at the low end and age upward, or enter at the top and age downward.
  generate
    if (MSW_FIRST) begin : g_msw
      assign w_next = {r_data[DW-WORD_W-1:0], i_word};
    end else begin : g_lsw
      assign w_next = {i_word, r_data[DW-1:WORD_W]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst || i_zero) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/stp_sr_stream.sv
// Collects NUM_WORDS serial words into one wide block and holds it until drained.
// Block valid the cycle after the last word is accepted; in_ready follows out_ready while full.
module stp_sr_stream
  import stp_pkg::*;
#(
  parameter int  WORD_W    = 32,
  parameter int  NUM_WORDS = 8,
  parameter bit  MSW_FIRST = 1'b1,
  localparam int CNT_W     = cnt_width(NUM_WORDS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [WORD_W-1:0]           i_in_word,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] o_parallel_out,
  output logic [CNT_W-1:0]            o_word_count
);

  stp_state_t       r_state;
  stp_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_drain;
  logic             w_shift;
  logic             w_last;

  assign w_accept = i_in_valid & o_in_ready;
  assign w_drain  = o_out_valid & i_out_ready;
  assign w_last   = (r_count == CNT_W'(NUM_WORDS - 1));
  // Clear wins over any same-cycle accept, so the word must not reach the register.
  assign w_shift  = w_accept & ~i_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_accept && w_last) w_state_nxt = FULL;
        FULL:    if (w_drain) w_state_nxt = COLLECT;
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  always_comb begin
    o_out_valid = (r_state == FULL);
    o_in_ready  = (r_state == COLLECT) | i_out_ready;
  end

  // A drain that coincides with an accept starts the next block at one word.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (r_state == FULL) begin
      if (w_drain) begin
        r_count <= w_accept ? CNT_W'(1) : '0;
      end
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_word_count = r_count;

  stp_word_shift #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .MSW_FIRST (MSW_FIRST)
  ) u_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_zero  (i_clear),
    .i_shift (w_shift),
    .i_word  (i_in_word),
    .o_data  (o_parallel_out)
  );

endmodule

// File: tb/tb_stp_sr_stream.sv
// Directed bench for stp_sr_stream; two instances cover both word orders on shared stimulus.
module tb_stp_sr_stream;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic [31:0]  in_word;
  logic         out_ready;

  logic         a_in_ready, b_in_ready;
  logic         a_out_valid, b_out_valid;
  logic [255:0] a_par, b_par;
  logic [3:0]   a_cnt, b_cnt;

  int checks;
  int failures;

  localparam logic [255:0] FILL_MSW =
    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] FILL_LSW =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [255:0] BP_MSW =
    256'h00000002_00000003_00000004_00000005_00000006_00000007_00000008_0000000A;
  localparam logic [255:0] BP_LSW =
    256'h0000000A_00000008_00000007_00000006_00000005_00000004_00000003_00000002;

  stp_sr_stream #(.WORD_W(32), .NUM_WORDS(8), .MSW_FIRST(1'b1)) u_msw (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (clear),
    .i_in_valid     (in_valid),
    .o_in_ready     (a_in_ready),
    .i_in_word      (in_word),
    .o_out_valid    (a_out_valid),
    .i_out_ready    (out_ready),
    .o_parallel_out (a_par),
    .o_word_count   (a_cnt)
  );

  stp_sr_stream #(.WORD_W(32), .NUM_WORDS(8), .MSW_FIRST(1'b0)) u_lsw (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (clear),
    .i_in_valid     (in_valid),
    .o_in_ready     (b_in_ready),
    .i_in_word      (in_word),
    .o_out_valid    (b_out_valid),
    .i_out_ready    (out_ready),
    .o_parallel_out (b_par),
    .o_word_count   (b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected block when words base, base+1, ... arrive in order.
  function automatic logic [255:0] exp_block(input logic [31:0] base, input bit msw);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (msw) r[(7-i)*32 +: 32] = base + 32'(i);
      else     r[i*32 +: 32]     = base + 32'(i);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b/%b want 0", a_out_valid, b_out_valid); end
    checks++; if (a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_count got %0d/%0d want 0", a_cnt, b_cnt); end
    checks++; if (a_par !== '0 || b_par !== '0) begin
      failures++; $display("FAIL reset_parallel got %h want 0", a_par); end
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b/%b want 1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send_word(32'(i));
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd7) begin
      failures++; $display("FAIL fill_seven got valid=%b cnt=%0d want 0/7", a_out_valid, a_cnt); end
    send_word(32'h8);
    checks++; if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
      failures++; $display("FAIL fill_out_valid got %b/%b want 1", a_out_valid, b_out_valid); end
    checks++; if (a_par !== FILL_MSW) begin
      failures++; $display("FAIL fill_msw got %h want %h", a_par, FILL_MSW); end
    checks++; if (b_par !== FILL_LSW) begin
      failures++; $display("FAIL fill_lsw got %h want %h", b_par, FILL_LSW); end
    checks++; if (a_cnt !== 4'd8 || b_cnt !== 4'd8) begin
      failures++; $display("FAIL fill_count got %0d/%0d want 8", a_cnt, b_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_in_ready got %b want 0", a_in_ready); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_word = 32'hDEAD_BEEF; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_cnt !== 4'd8 || a_par !== FILL_MSW || b_par !== FILL_LSW) begin
        failures++; $display("FAIL bp_hold c=%0d got valid=%b cnt=%0d par=%h", c, a_out_valid, a_cnt, a_par); end
    end
    in_word = 32'hA; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_passthru got %b want 1", a_in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd1 || b_cnt !== 4'd1) begin
      failures++; $display("FAIL bp_drain_accept got valid=%b cnt=%0d want 0/1", a_out_valid, a_cnt); end
    checks++; if (a_par !== BP_MSW || b_par !== BP_LSW) begin
      failures++; $display("FAIL bp_shift got %h / %h", a_par, b_par); end
  endtask

  task automatic test_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 1; i <= 3; i++) send_word(32'(i));
    checks++; if (a_cnt !== 4'd3) begin
      failures++; $display("FAIL clear_pre got cnt=%0d want 3", a_cnt); end
    clear = 1'b1; in_valid = 1'b1; in_word = 32'h55;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (a_cnt !== 4'd0 || a_par !== '0 || b_par !== '0 || a_out_valid !== 1'b0) begin
      failures++; $display("FAIL clear_mid got cnt=%0d par=%h", a_cnt, a_par); end
    for (int i = 0; i < 8; i++) send_word(32'h11 + 32'(i));
    checks++; if (a_out_valid !== 1'b1 || a_par !== exp_block(32'h11, 1'b1) || b_par !== exp_block(32'h11, 1'b0)) begin
      failures++; $display("FAIL clear_next_block got valid=%b par=%h", a_out_valid, a_par); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd0) begin
      failures++; $display("FAIL b2b_predrain got valid=%b cnt=%0d", a_out_valid, a_cnt); end
    for (int j = 0; j < 24; j++) begin
      in_valid = 1'b1;
      in_word  = 32'h100 + 32'(j);
      #1;
      checks++; if (a_in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready j=%0d got %b want 1", j, a_in_ready); end
      tick();
      checks++; if (a_out_valid !== ((j % 8) == 7) || a_cnt !== 4'((j % 8) + 1)) begin
        failures++; $display("FAIL b2b_state j=%0d got valid=%b cnt=%0d", j, a_out_valid, a_cnt); end
      if ((j % 8) == 7) begin
        checks++;
        if (a_par !== exp_block(32'h100 + 32'(j - 7), 1'b1) || b_par !== exp_block(32'h100 + 32'(j - 7), 1'b0)) begin
          failures++; $display("FAIL b2b_block j=%0d got %h", j, a_par); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd0) begin
      failures++; $display("FAIL b2b_tail got valid=%b cnt=%0d", a_out_valid, a_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    for (int i = 0; i < 8; i++) send_word(32'h200 + 32'(i));
    checks++; if (a_out_valid !== 1'b1) begin
      failures++; $display("FAIL rstfull_pre got %b want 1", a_out_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd0 || a_par !== '0 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL rstfull got valid=%b cnt=%0d rdy=%b par=%h", a_out_valid, a_cnt, a_in_ready, a_par); end
  endtask

  task automatic test_clear_drain();
    for (int i = 0; i < 8; i++) send_word(32'h300 + 32'(i));
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h77;
    tick();
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd0 || a_par !== '0 || b_par !== '0) begin
      failures++; $display("FAIL clear_drain got valid=%b cnt=%0d par=%h", a_out_valid, a_cnt, a_par); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_reset_full();
    test_clear_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
